stride_perm_pp: RTL
===================

STRIDE_PERM_PP -- requirements
Module: stride_perm_pp

Interface
REQ-001 Parameter NB_DATA, default 16: bits per sample, complex pair of 8-bit parts.
REQ-002 Parameter N_POINTS, default 32: samples per frame; SHALL be a multiple of N_LANES.
REQ-003 Parameter N_LANES, default 4: output samples per beat; STRIDE = N_POINTS/N_LANES SHALL be a power of two, >=2.
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_data  in  N_POINTS*NB_DATA  frame; sample k at bits [k*NB_DATA +: NB_DATA].
REQ-007 i_valid  in  1  frame present on i_data.
REQ-008 o_ready  out  1  frame accepted at this edge if i_valid is also high.
REQ-009 i_mode  in  1  0 = stride order, 1 = natural order; sampled with the frame.
REQ-010 i_enable  in  1  global advance enable; low freezes all state.
REQ-011 o_data  out  N_LANES*NB_DATA  output beat; lane j at bits [j*NB_DATA +: NB_DATA].
REQ-012 o_valid  out  1  o_data holds a valid beat.
REQ-013 o_last  out  1  marks the final beat (beat STRIDE-1) of a frame.
REQ-014 i_ready  in  1  downstream accepts the beat when o_valid and i_ready are both high at an edge.

Function
REQ-015 The block SHALL hold two frame banks (ping-pong), each N_POINTS samples plus a mode bit and a full flag.
REQ-016 o_ready SHALL equal i_enable AND NOT full[wr_sel] (combinational).
REQ-017 Accept (i_valid & o_ready) SHALL write all samples and i_mode into bank wr_sel, set full[wr_sel], and toggle wr_sel.
REQ-018 Read side SHALL emit from bank rd_sel while full[rd_sel]; beat counter k runs 0..STRIDE-1.
REQ-019 Stride mode: lane j of beat k SHALL be sample k + j*STRIDE.
REQ-020 Natural mode: lane j of beat k SHALL be sample k*N_LANES + j.
REQ-021 o_data/o_valid/o_last SHALL be registered and load a new beat only when o_valid is low or i_ready is high.
REQ-022 While o_valid is high and i_ready is low, o_data, o_last and k SHALL hold stable.
REQ-023 Loading beat STRIDE-1 SHALL clear full[rd_sel], toggle rd_sel and wrap k to 0; the next bank's beat 0 follows on the next load with no gap.
REQ-024 Latency: a frame accepted at edge t into an idle read side SHALL show beat 0 with o_valid high after edge t+1.
REQ-025 Accept into one bank and drain-completion of the other at the same edge SHALL both take effect.
REQ-026 Both banks full: o_ready SHALL be low until the read bank's last beat is loaded.
REQ-027 o_valid SHALL drop after the last handshake once no bank is full.
REQ-028 i_enable low SHALL block accept, beat load and counter advance; outputs hold their values.
REQ-029 Per-bank mode SHALL apply to that whole frame, independent of i_mode changes during emission.

Reset
REQ-030 On i_rst_n low, immediately: full flags 0, wr_sel 0, rd_sel 0, k 0, o_valid 0, o_last 0, o_data 0; any partial frame is discarded.
REQ-031 Bank sample storage SHALL NOT require reset.
REQ-032 After release, o_ready SHALL be high whenever i_enable is high.

Verification (N_POINTS=32, N_LANES=4, sample k = k, i_ready=1 unless stated)
REQ-033 Stride frame -> 8 beats: beat0 {0,8,16,24}, beat7 {7,15,23,31}, o_last only on beat7.
REQ-034 Natural frame -> beat0 {0,1,2,3}, beat7 {28,29,30,31}.
REQ-035 Frames A and B on consecutive cycles, then C held -> o_ready low after B; 16 gapless beats; C accepted the cycle after A's beat7 loads.
REQ-036 i_ready low 3 cycles while beat2 {2,10,18,26} shown -> beat2 held stable, then beats 3..7 follow, nothing lost or duplicated.
REQ-037 i_rst_n low during beat4 -> o_valid 0 at once; after release o_ready 1; next frame starts at beat0.
REQ-038 i_enable low 2 cycles mid-frame -> no beat advance or accept; emission resumes at the same beat.

Source files
------------

// File: rtl/stride_perm_pp.sv
// Ping-pong frame buffer that re-emits each stored frame as STRIDE beats of N_LANES samples,
// in stride (column) or natural (row) order chosen per frame.
module stride_perm_pp #(
   parameter int NB_DATA  = 16,
   parameter int N_POINTS = 32,
   parameter int N_LANES  = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [N_POINTS*NB_DATA-1:0]   i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic                          i_mode,
   input  logic                          i_enable,
   output logic [N_LANES*NB_DATA-1:0]    o_data,
   output logic                          o_valid,
   output logic                          o_last,
   input  logic                          i_ready
);

   localparam int STRIDE = N_POINTS / N_LANES;
   localparam int KW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int IW     = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

   logic [NB_DATA-1:0]          r_bank [2][N_POINTS];
   logic [1:0]                  r_mode;
   logic [1:0]                  r_full;
   logic                        r_wr_sel;
   logic                        r_rd_sel;
   logic [KW-1:0]               r_k;
   logic [N_LANES*NB_DATA-1:0]  r_data_p1;
   logic                        r_vld_p1;
   logic                        r_last_p1;

   logic                        w_accept;
   logic                        w_load;
   logic                        w_last_beat;
   logic [N_LANES*NB_DATA-1:0]  w_beat;
   int                          w_idx;

   assign o_ready     = i_enable & ~r_full[r_wr_sel];
   assign w_accept    = i_valid & o_ready;
   assign w_load      = i_enable & (~r_vld_p1 | i_ready);
   assign w_last_beat = (r_k == KW'(STRIDE - 1));

   // Gather beat k of the read bank; the bank's stored mode picks the sample order.
   always_comb begin
      w_beat = '0;
      w_idx  = 0;
      for (int j = 0; j < N_LANES; j++) begin
         if (r_mode[r_rd_sel])
            w_idx = int'(r_k) * N_LANES + j;
         else
            w_idx = int'(r_k) + j * STRIDE;
         w_beat[j*NB_DATA +: NB_DATA] = r_bank[r_rd_sel][w_idx[IW-1:0]];
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         for (int i = 0; i < N_POINTS; i++)
            r_bank[r_wr_sel][i] <= i_data[i*NB_DATA +: NB_DATA];
      end
   end

   // Accept and drain touch different banks: a full read bank plus an empty write bank.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_full    <= '0;
         r_mode    <= '0;
         r_wr_sel  <= 1'b0;
         r_rd_sel  <= 1'b0;
         r_k       <= '0;
         r_data_p1 <= '0;
         r_vld_p1  <= 1'b0;
         r_last_p1 <= 1'b0;
      end else begin
         if (w_accept) begin
            r_full[r_wr_sel] <= 1'b1;
            r_mode[r_wr_sel] <= i_mode;
            r_wr_sel         <= ~r_wr_sel;
         end
         if (w_load) begin
            r_vld_p1  <= r_full[r_rd_sel];
            r_last_p1 <= r_full[r_rd_sel] & w_last_beat;
            if (r_full[r_rd_sel]) begin
               r_data_p1 <= w_beat;
               if (w_last_beat) begin
                  r_full[r_rd_sel] <= 1'b0;
                  r_rd_sel         <= ~r_rd_sel;
                  r_k              <= '0;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
         end
      end
   end

   assign o_data  = r_data_p1;
   assign o_valid = r_vld_p1;
   assign o_last  = r_last_p1;

endmodule
